// File: rtl/turbo_pkt_arb_pkg.sv
// Shared state encoding and constants for the turbo decoder packet arbiter.
package turbo_pkt_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t busy_state(input logic idx);
    return idx ? BUSY1 : BUSY0;
  endfunction

endpackage

// File: rtl/turbo_pkt_arb_tag_fifo.sv
// One-bit tag FIFO remembering which requester owns each packet inside the decoder.
module tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic mem [2**AW];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] count_reg;
  logic do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so it reads 0 when empty instead of a stale entry.
  assign head    = empty ? 1'b0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/turbo_pkt_arb.sv
// Packet-level round-robin arbiter feeding two soft-bit streams into one turbo decoder,
// tracking ownership of in-flight packets so the decoder output can be steered back.
module turbo_pkt_arb
  import turbo_pkt_arb_pkg::*;
#(
  parameter int ST           = 12,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  input  logic          s0_sop,
  input  logic          s0_eop,
  input  logic [ST-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic          s1_sop,
  input  logic          s1_eop,
  input  logic [ST-1:0] s1_data,
  output logic          s1_ready,
  output logic          trb_sink_valid,
  output logic          trb_sink_sop,
  output logic          trb_sink_eop,
  output logic [ST-1:0] trb_sink_data,
  input  logic          trb_sink_ready,
  input  logic          trb_source_valid,
  input  logic          trb_source_ready,
  input  logic          trb_source_eop,
  output logic          out_chan,
  output logic          out_chan_valid,
  output logic [2:0]    inflight,
  output logic [1:0]    err
);

  arb_state_t state_reg, state_next;
  logic rr_reg, rr_next;
  logic first_reg, first_next;
  logic [2:0] inflight_reg, inflight_next;
  logic [NUM_REQ-1:0] err_reg, err_next;

  logic [NUM_REQ-1:0] s_valid, s_sop, s_eop, s_ready, req;
  logic [ST-1:0] s_data [NUM_REQ];
  logic cur, win, can_grant, push, pop_ok;
  logic fifo_empty, fifo_full, fifo_head;
  logic sink_valid_c, sink_sop_c, sink_eop_c;
  logic [ST-1:0] sink_data_c;

  assign s_valid   = {s1_valid, s0_valid};
  assign s_sop     = {s1_sop, s0_sop};
  assign s_eop     = {s1_eop, s0_eop};
  assign s_data[0] = s0_data;
  assign s_data[1] = s1_data;

  assign cur       = (state_reg == BUSY1);
  assign req       = s_valid & s_sop;
  assign can_grant = (inflight_reg < 3'(MAX_INFLIGHT)) && !fifo_full;
  // A completion seen while nothing is tracked is ignored rather than underflowing.
  assign pop_ok    = trb_source_valid && trb_source_ready && trb_source_eop && !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    first_next   = first_reg;
    err_next     = err_reg;
    s_ready      = '0;
    sink_valid_c = 1'b0;
    sink_sop_c   = 1'b0;
    sink_eop_c   = 1'b0;
    sink_data_c  = '0;
    push         = 1'b0;
    win          = rr_reg;
    case (state_reg)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (s_valid[i] && !s_sop[i]) begin
            s_ready[i]  = 1'b1;
            err_next[i] = 1'b1;
          end
        end
        win = (req == 2'b11) ? rr_reg : req[1];
        if ((req != '0) && can_grant) begin
          state_next = busy_state(win);
          rr_next    = !win;
          first_next = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        sink_valid_c = s_valid[cur];
        sink_sop_c   = s_sop[cur];
        sink_eop_c   = s_eop[cur];
        sink_data_c  = s_data[cur];
        s_ready[cur] = trb_sink_ready;
        if (s_valid[cur] && trb_sink_ready) begin
          first_next = 1'b0;
          if (s_sop[cur] && !first_reg) err_next[cur] = 1'b1;
          if (s_eop[cur]) begin
            state_next = IDLE;
            push       = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop_ok})
      2'b10:   inflight_next = inflight_reg + 3'(1);
      2'b01:   inflight_next = inflight_reg - 3'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_reg       <= 1'b0;
      first_reg    <= 1'b0;
      inflight_reg <= '0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      first_reg    <= first_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_next;
    end
  end

  tag_fifo #(
    .DEPTH(MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop_ok),
    .din  (cur),
    .head (fifo_head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Handshake outputs are held off for the whole reset, not just until the state clears.
  assign s0_ready       = s_ready[0] && rst_n;
  assign s1_ready       = s_ready[1] && rst_n;
  assign trb_sink_valid = sink_valid_c && rst_n;
  assign trb_sink_sop   = sink_sop_c;
  assign trb_sink_eop   = sink_eop_c;
  assign trb_sink_data  = sink_data_c;
  assign out_chan       = fifo_head;
  assign out_chan_valid = !fifo_empty;
  assign inflight       = inflight_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_turbo_pkt_arb.sv
// Self-checking bench for turbo_pkt_arb: IDLE vector table, directed corner sequences,
// and randomized traffic scored against a packet-level reference model.
module tb_turbo_pkt_arb;

  localparam int ST   = 12;
  localparam int MAXI = 2;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [ST-1:0] data;
  } beat_t;

  typedef struct {
    logic       v0, s0, v1, s1;
    logic [1:0] rdy;
    logic [1:0] err;
    logic       gv;
    logic       gid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tv [2];
  logic ts [2];
  logic te [2];
  logic [ST-1:0] td [2];
  logic s0_ready, s1_ready;
  logic sink_valid, sink_sop, sink_eop, sink_ready;
  logic [ST-1:0] sink_data;
  logic tsv, tsr, tse;
  logic out_chan, out_chan_valid;
  logic [2:0] inflight;
  logic [1:0] err;

  always #5 clk = ~clk;

  turbo_pkt_arb #(.ST(ST), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(tv[0]), .s0_sop(ts[0]), .s0_eop(te[0]), .s0_data(td[0]), .s0_ready(s0_ready),
    .s1_valid(tv[1]), .s1_sop(ts[1]), .s1_eop(te[1]), .s1_data(td[1]), .s1_ready(s1_ready),
    .trb_sink_valid(sink_valid), .trb_sink_sop(sink_sop), .trb_sink_eop(sink_eop),
    .trb_sink_data(sink_data), .trb_sink_ready(sink_ready),
    .trb_source_valid(tsv), .trb_source_ready(tsr), .trb_source_eop(tse),
    .out_chan(out_chan), .out_chan_valid(out_chan_valid), .inflight(inflight), .err(err)
  );

  int n_checks = 0;
  int n_pass = 0;

  beat_t src_q [2][$];
  beat_t sent_q [2][$];
  bit tag_q [$];
  bit rdy_pat [$];
  int m_inflight;
  logic [10:0] seq [2];
  int vprob, rprob, cprob;
  bit force_cmpl, sb_on, owner;
  bit hs [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_pkt(input int i, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      b.data = {i[0], seq[i]};
      seq[i] = seq[i] + 11'd1;
      src_q[i].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      hs[i] = 1'b0;
      if (src_q[i].size() > 0 && chance(vprob)) begin
        tv[i] = 1'b1; ts[i] = src_q[i][0].sop; te[i] = src_q[i][0].eop; td[i] = src_q[i][0].data;
      end else begin
        tv[i] = 1'b0; ts[i] = 1'b0; te[i] = 1'b0; td[i] = '0;
      end
    end
    if (rdy_pat.size() > 0) sink_ready = rdy_pat.pop_front();
    else sink_ready = chance(rprob);
    if (force_cmpl) begin
      tsv = 1'b1; tsr = 1'b1; tse = 1'b1; force_cmpl = 1'b0;
    end else begin
      tsv = chance(cprob); tsr = chance(80); tse = chance(70);
    end
  endtask

  // Packet-level reference: beats must leave the sink in the order each requester
  // handed them over, packets never interleave, and the tag queue follows sink eops.
  task automatic observe();
    bit push_m, pop_m, id;
    beat_t b, e;
    hs[0] = tv[0] && s0_ready;
    hs[1] = tv[1] && s1_ready;
    if (sb_on) begin
      push_m = 1'b0;
      id = 1'b0;
      check("inflight", inflight, m_inflight);
      check("out_chan_valid", out_chan_valid, tag_q.size() != 0);
      if (tag_q.size() != 0) check("out_chan", out_chan, tag_q[0]);
      for (int i = 0; i < 2; i++) if (hs[i]) sent_q[i].push_back(src_q[i][0]);
      check("xfer_match", int'(hs[0]) + int'(hs[1]), sink_valid && sink_ready);
      if (sink_valid && sink_ready) begin
        id = sink_data[ST-1];
        if (sink_sop) begin
          check("grant_limit", m_inflight < MAXI, 1);
          owner = id;
        end else begin
          check("owner", id, owner);
        end
        if (sent_q[id].size() == 0) fail("sink_extra_beat");
        else begin
          e = sent_q[id].pop_front();
          b = {sink_sop, sink_eop, sink_data};
          check("beat", b, e);
        end
        push_m = sink_eop;
      end
      pop_m = tsv && tsr && tse && (tag_q.size() != 0);
      if (pop_m) void'(tag_q.pop_front());
      if (push_m) tag_q.push_back(id);
      m_inflight += int'(push_m) - int'(pop_m);
    end
  endtask

  task automatic cycle();
    observe();
    tick();
    drive();
    #1;
  endtask

  task automatic start();
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete(); sent_q[i].delete();
      hs[i] = 1'b0; tv[i] = 1'b0; ts[i] = 1'b0; te[i] = 1'b0; td[i] = '0;
    end
    tag_q.delete(); rdy_pat.delete();
    m_inflight = 0; force_cmpl = 1'b0;
    sink_ready = 1'b0; tsv = 1'b0; tsr = 1'b0; tse = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vecs [8];
  int exp_sv [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
  int exp_id [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
  int pat_j [5] = '{0, 1, 1, 2, 2};
  bit pat_r [5] = '{1, 0, 1, 0, 1};

  initial begin
    logic [ST-1:0] expd;
    logic [10:0] base;
    int guard;
    seq[0] = '0; seq[1] = '0;
    vprob = 100; rprob = 100; cprob = 0; sb_on = 1'b0; owner = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0; ts[i] = 1'b0; te[i] = 1'b0; td[i] = '0; hs[i] = 1'b0;
    end
    sink_ready = 1'b0; tsv = 1'b0; tsr = 1'b0; tse = 1'b0;

    // IDLE behaviour from a fresh reset: drain readies, sticky err, grant winner.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      rst_n = 1'b0;
      tv[0] = 1'b0; tv[1] = 1'b0; ts[0] = 1'b0; ts[1] = 1'b0;
      #1;
      rst_n = 1'b1;
      check("rst_err", err, 2'b00);
      check("rst_inflight", inflight, 0);
      check("rst_ocv", out_chan_valid, 0);
      tv[0] = vecs[v].v0; ts[0] = vecs[v].s0; tv[1] = vecs[v].v1; ts[1] = vecs[v].s1;
      te[0] = 1'b0; te[1] = 1'b0; td[0] = 12'h0AA; td[1] = 12'h855; sink_ready = 1'b1;
      #1;
      check("vec_ready", {s1_ready, s0_ready}, vecs[v].rdy);
      check("vec_idle_sv", sink_valid, 0);
      tick();
      check("vec_err", err, vecs[v].err);
      check("vec_grant_sv", sink_valid, vecs[v].gv);
      if (vecs[v].gv) check("vec_grant_data", sink_data, vecs[v].gid ? 12'h855 : 12'h0AA);
    end

    // Two 3-beat packets from reset: s0 in cycles 2-4, s1 in cycles 6-8.
    do_reset();
    sb_on = 1'b1; vprob = 100; rprob = 100; cprob = 0;
    gen_pkt(0, 3); gen_pkt(1, 3);
    start();
    for (int k = 0; k < 9; k++) begin
      check("seq_sink_valid", sink_valid, exp_sv[k]);
      if (exp_sv[k] != 0) check("seq_owner", sink_data[ST-1], exp_id[k]);
      cycle();
    end
    check("seq_tags_n", inflight, 2);
    check("seq_tag0", out_chan, 0);
    force_cmpl = 1'b1;
    cycle();
    cycle();
    check("seq_tag1", out_chan, 1);
    check("seq_infl1", inflight, 1);

    // Inflight limit holds a third packet; one completion releases it after an idle cycle,
    // and a simultaneous push/pop keeps inflight while out_chan advances.
    do_reset();
    gen_pkt(0, 2); gen_pkt(1, 2); gen_pkt(0, 1);
    start();
    repeat (15) cycle();
    check("hold_inflight", inflight, 2);
    check("hold_s0_ready", s0_ready, 0);
    check("hold_sink_valid", sink_valid, 0);
    force_cmpl = 1'b1;
    cycle();
    check("cmpl_inflight", inflight, 2);
    cycle();
    check("rel_idle_sv", sink_valid, 0);
    check("rel_inflight", inflight, 1);
    check("rel_out_chan", out_chan, 1);
    force_cmpl = 1'b1;
    cycle();
    check("rel_sv", sink_valid, 1);
    check("rel_sop", sink_sop, 1);
    check("rel_s0_ready", s0_ready, 1);
    check("pp_out_chan_before", out_chan, 1);
    cycle();
    check("pp_inflight", inflight, 1);
    check("pp_out_chan_after", out_chan, 0);
    check("pp_ocv", out_chan_valid, 1);

    // Sink backpressure 1,0,1,0 during a BUSY1 packet.
    do_reset();
    base = seq[1];
    gen_pkt(1, 3);
    start();
    gen_pkt(0, 2);
    for (int k = 0; k < 5; k++) rdy_pat.push_back(pat_r[k]);
    cycle();
    for (int k = 0; k < 5; k++) begin
      expd = {1'b1, base + 11'(pat_j[k])};
      check("bp_s0_ready", s0_ready, 0);
      check("bp_s1_ready", s1_ready, pat_r[k]);
      check("bp_sink_valid", sink_valid, 1);
      check("bp_data", sink_data, expd);
      cycle();
    end
    check("bp_idle_after", sink_valid, 0);

    // Drain of a sop-less beat and a completion against an empty tag FIFO.
    do_reset();
    sb_on = 1'b0;
    tv[1] = 1'b1; ts[1] = 1'b0; td[1] = 12'h812; sink_ready = 1'b1;
    #1;
    check("drain_ready", s1_ready, 1);
    tick();
    check("drain_err", err, 2'b10);
    tv[1] = 1'b0; tsv = 1'b1; tsr = 1'b1; tse = 1'b1;
    tick();
    tsv = 1'b0;
    #1;
    check("empty_pop_inflight", inflight, 0);
    check("empty_pop_ocv", out_chan_valid, 0);
    check("err_sticky", err, 2'b10);

    // Reset mid-packet in BUSY0, then a normal packet.
    do_reset();
    sb_on = 1'b1;
    gen_pkt(0, 4);
    start();
    cycle();
    cycle();
    check("mid_sink_valid", sink_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_sink_valid", sink_valid, 0);
    check("mrst_s0_ready", s0_ready, 0);
    check("mrst_inflight", inflight, 0);
    check("mrst_ocv", out_chan_valid, 0);
    check("mrst_out_chan", out_chan, 0);
    check("mrst_err", err, 0);
    do_reset();
    gen_pkt(0, 2);
    start();
    cycle();
    check("post_rst_sv", sink_valid, 1);
    check("post_rst_sop", sink_sop, 1);
    check("post_rst_err", err, 0);
    cycle();
    cycle();

    // Randomized traffic against the reference model, then drain.
    do_reset();
    vprob = 70; rprob = 70; cprob = 30;
    start();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if (src_q[i].size() < 6 && chance(20)) gen_pkt(i, 1 + int'($urandom_range(3)));
      cycle();
    end
    vprob = 100; rprob = 100; cprob = 100;
    guard = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || tag_q.size() > 0) && guard < 500) begin
      cycle();
      guard++;
    end
    if (guard >= 500) fail("drain_timeout");
    check("rand_left0", sent_q[0].size(), 0);
    check("rand_left1", sent_q[1].size(), 0);
    check("rand_inflight", inflight, 0);
    check("rand_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/turbo_pkt_arb.md
TURBO_PKT_ARB -- requirements
Module: turbo_pkt_arb

Interface
REQ-001 Parameter ST, default 12, soft-bit sample width of each stream beat.
REQ-002 Parameter MAX_INFLIGHT, default 2, maximum packets accepted by the turbo decoder but not yet fully output; legal range 1..7.
REQ-003 Ports, in order:
- clk  in  1  single clock; the decoder domain.
- rst_n  in  1  asynchronous active-low reset.
- s0_valid/s0_sop/s0_eop  in  1 each  requester 0 stream control.
- s0_data  in  ST  requester 0 stream data.
- s0_ready  out  1  requester 0 backpressure.
- s1_valid/s1_sop/s1_eop/s1_data/s1_ready  same as s0, for requester 1.
- trb_sink_valid/trb_sink_sop/trb_sink_eop  out  1 each  decoder sink control.
- trb_sink_data  out  ST  decoder sink data.
- trb_sink_ready  in  1  decoder sink ready.
- trb_source_valid/trb_source_ready/trb_source_eop  in  1 each  monitored decoder output handshake.
- out_chan  out  1  requester id owning the packet currently at the decoder output.
- out_chan_valid  out  1  out_chan is meaningful (tag FIFO non-empty).
- inflight  out  3  packets outstanding.
- err  out  2  sticky per-requester protocol error; bit i for requester i.

Function
REQ-004 FSM states: IDLE, BUSY0, BUSY1; a beat transfers on valid&ready.
REQ-005 In IDLE, sX_valid&sX_sop is a request; a grant is issued only if inflight < MAX_INFLIGHT.
REQ-006 Arbitration is packet-level round-robin: pointer rr names the preferred requester; if only one requests, it wins.
REQ-007 On grant, FSM enters BUSYx on the next edge; rr becomes the loser's index.
REQ-008 In IDLE, trb_sink_valid=0 and no sop beat is accepted; arbitration costs exactly one idle cycle per packet.
REQ-009 In BUSYx, trb_sink_valid/sop/eop/data = sX signals combinationally; sX_ready = trb_sink_ready; the other requester's ready = 0.
REQ-010 In BUSYx, an accepted beat with sX_eop returns FSM to IDLE, increments inflight, and pushes x into the tag FIFO; a single-beat packet (sop&eop) is legal.
REQ-011 In IDLE, a requester with valid & !sop is drained: ready=1 for that beat, beat discarded, err[x] set.
REQ-012 In BUSYx, an accepted beat with sop other than the first beat sets err[x]; the beat is forwarded unchanged.
REQ-013 Completion: trb_source_valid&trb_source_ready&trb_source_eop pops the tag FIFO and decrements inflight.
REQ-014 If completion and the REQ-010 push occur in the same cycle, inflight is unchanged and FIFO ordering is preserved.
REQ-015 Completion with an empty FIFO is ignored: no underflow, inflight stays 0.
REQ-016 out_chan = FIFO head and out_chan_valid = !empty, both registered-state driven with no input-to-output combinational path.
REQ-017 The tag FIFO depth equals MAX_INFLIGHT; overflow is impossible by REQ-005.
REQ-018 err bits clear only on reset.

Reset
REQ-019 On rst_n low, asynchronously: FSM = IDLE, rr = 0, inflight = 0, FIFO empty, out_chan = 0, out_chan_valid = 0, err = 0.
REQ-020 During reset, s0_ready = s1_ready = 0 and trb_sink_valid = 0.
REQ-021 A packet cut by reset is abandoned; after reset, the first beat from each requester must carry sop.

Structure
REQ-022 The FSM state encoding and the requester-count constant (2) reside in the shared turbo package.
REQ-023 The tag FIFO is one sub-module, tag_fifo (width 1, depth MAX_INFLIGHT, push/pop/head/empty/full).

Verification
REQ-024 Both requesters issue a 3-beat packet from reset with trb_sink_ready=1 -> s0 packet forwarded in cycles 2-4, s1 packet in cycles 6-8; tag FIFO holds 0,1.
REQ-025 MAX_INFLIGHT=2, three packets queued, no completions -> third packet is held with s_ready=0 and inflight=2; one trb_source eop -> third is granted after 1 idle cycle.
REQ-026 trb_sink_ready toggled 1,0,1,0 during a BUSY1 packet -> data stalls exactly on the 0 cycles, s0_ready=0 throughout, and no beat is lost or duplicated.
REQ-027 Push (eop accepted) and pop (source eop) in the same cycle with inflight=1 -> inflight stays 1; out_chan advances to the next tag.
REQ-028 s1 drives valid without sop in IDLE -> beat drained, err=2'b10; a source eop with an empty FIFO -> inflight stays 0.
REQ-029 rst_n asserted mid-packet in BUSY0 -> all outputs at reset values immediately; next s0 sop packet is granted normally.
